// File: rtl/mem_arb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared widths, tag type and helpers for mem_read_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 64;
    localparam int MEM_LEN_W  = 32;
    localparam int MEM_DATA_W = 512;
    localparam int MEM_KEEP_W = MEM_DATA_W / 8;
    localparam int MEM_STS_W  = 8;

    // Tags carry a requester index; 4 bits covers up to 16 requesters.
    localparam int TAG_W = 4;
    typedef logic [TAG_W-1:0] tag_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_read_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_read_arbiter_if
// Purpose  : Requester command/data/status and memory-side bus bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_read_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]                 s_cmd_valid;
    logic [NUM_REQ-1:0]                 s_cmd_ready;
    logic [NUM_REQ-1:0][MEM_ADDR_W-1:0] s_cmd_address;
    logic [NUM_REQ-1:0][MEM_LEN_W-1:0]  s_cmd_length;

    logic                               m_cmd_valid;
    logic                               m_cmd_ready;
    logic [MEM_ADDR_W-1:0]              m_cmd_address;
    logic [MEM_LEN_W-1:0]               m_cmd_length;

    logic                               s_mem_data_valid;
    logic                               s_mem_data_ready;
    logic                               s_mem_data_last;
    logic [MEM_DATA_W-1:0]              s_mem_data;
    logic [MEM_KEEP_W-1:0]              s_mem_keep;

    logic [NUM_REQ-1:0]                 m_req_data_valid;
    logic [NUM_REQ-1:0]                 m_req_data_last;
    logic [MEM_DATA_W-1:0]              m_req_data;
    logic [MEM_KEEP_W-1:0]              m_req_keep;
    logic [NUM_REQ-1:0]                 m_req_data_ready;

    logic                               s_mem_sts_valid;
    logic                               s_mem_sts_ready;
    logic [MEM_STS_W-1:0]               s_mem_sts_data;

    logic [NUM_REQ-1:0]                 m_req_sts_valid;
    logic [MEM_STS_W-1:0]               m_req_sts_data;
    logic [NUM_REQ-1:0]                 m_req_sts_ready;

    // Arbiter view
    modport slave (
        input  s_cmd_valid, s_cmd_address, s_cmd_length,
        output s_cmd_ready,
        output m_cmd_valid, m_cmd_address, m_cmd_length,
        input  m_cmd_ready,
        input  s_mem_data_valid, s_mem_data_last, s_mem_data, s_mem_keep,
        output s_mem_data_ready,
        output m_req_data_valid, m_req_data_last, m_req_data, m_req_keep,
        input  m_req_data_ready,
        input  s_mem_sts_valid, s_mem_sts_data,
        output s_mem_sts_ready,
        output m_req_sts_valid, m_req_sts_data,
        input  m_req_sts_ready
    );

    // Environment view (requesters plus memory)
    modport master (
        output s_cmd_valid, s_cmd_address, s_cmd_length,
        input  s_cmd_ready,
        input  m_cmd_valid, m_cmd_address, m_cmd_length,
        output m_cmd_ready,
        output s_mem_data_valid, s_mem_data_last, s_mem_data, s_mem_keep,
        input  s_mem_data_ready,
        input  m_req_data_valid, m_req_data_last, m_req_data, m_req_keep,
        output m_req_data_ready,
        output s_mem_sts_valid, s_mem_sts_data,
        input  s_mem_sts_ready,
        input  m_req_sts_valid, m_req_sts_data,
        output m_req_sts_ready
    );

endinterface
`default_nettype wire

// File: rtl/tag_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tag_fifo
// Purpose  : Synchronous FIFO of requester tags with full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_push,
    input  tag_t      i_data,
    input  wire logic i_pop,
    output tag_t      o_data,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    tag_t        r_mem [DEPTH];
    logic        w_push;
    logic        w_pop;

    // Full blocks a push even if the head pops in the same cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/mem_read_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_read_arbiter
// Purpose  : Shares one memory read channel among NUM_REQ requesters and
//            steers returned data/status back by tag order.
//            Option: MEM_ARB_STRICT_PRIO_EN selects fixed priority (index 0
//            highest) instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int TAG_DEPTH = 8
)(
    input  wire logic                   net_clk,
    input  wire logic                   net_areset,
    mem_read_arbiter_if.slave           bus,
    output logic [$clog2(TAG_DEPTH):0]  outstanding
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int OUT_W = $clog2(TAG_DEPTH) + 1;

    logic [IDX_W-1:0]      w_grant;
    logic                  w_grant_any;
    logic                  w_can_accept;
    logic                  w_accept;
    tag_t                  w_push_tag;

    logic                  r_cmd_valid;
    logic [MEM_ADDR_W-1:0] r_cmd_address;
    logic [MEM_LEN_W-1:0]  r_cmd_length;
    logic [OUT_W-1:0]      r_outstanding;

    tag_t                  w_data_head;
    tag_t                  w_sts_head;
    logic                  w_data_full;
    logic                  w_data_empty;
    logic                  w_sts_full;
    logic                  w_sts_empty;
    logic                  w_data_pop;
    logic                  w_sts_pop;

`ifdef MEM_ARB_STRICT_PRIO_EN
    always_comb begin
        w_grant_any = 1'b0;
        w_grant     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.s_cmd_valid[i]) begin
                w_grant_any = 1'b1;
                w_grant     = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] r_rr_ptr;

    // Lowest valid index overall, then overridden by lowest valid at/after pointer.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.s_cmd_valid[i]) begin
                w_grant_any = 1'b1;
                w_grant     = IDX_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.s_cmd_valid[i] && (IDX_W'(i) >= r_rr_ptr)) begin
                w_grant = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge net_clk or posedge net_areset) begin
        if (net_areset) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_grant == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant + IDX_W'(1);
        end
    end
`endif

    assign w_can_accept = (!r_cmd_valid || bus.m_cmd_ready) &&
                          !w_data_full && !w_sts_full && !net_areset;
    assign w_accept     = w_grant_any && w_can_accept;
    assign w_push_tag   = tag_t'(w_grant);

    always_comb begin
        bus.s_cmd_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.s_cmd_ready[i] = w_accept && (w_grant == IDX_W'(i));
        end
    end

    always_ff @(posedge net_clk or posedge net_areset) begin
        if (net_areset) begin
            r_cmd_valid   <= 1'b0;
            r_cmd_address <= '0;
            r_cmd_length  <= '0;
        end else if (w_accept) begin
            r_cmd_valid   <= 1'b1;
            r_cmd_address <= bus.s_cmd_address[w_grant];
            r_cmd_length  <= bus.s_cmd_length[w_grant];
        end else if (bus.m_cmd_ready) begin
            r_cmd_valid   <= 1'b0;
        end
    end

    assign bus.m_cmd_valid   = r_cmd_valid;
    assign bus.m_cmd_address = r_cmd_address;
    assign bus.m_cmd_length  = r_cmd_length;

    tag_fifo #(.DEPTH(TAG_DEPTH)) u_data_tag (
        .clk     (net_clk),
        .rst     (net_areset),
        .i_push  (w_accept),
        .i_data  (w_push_tag),
        .i_pop   (w_data_pop),
        .o_data  (w_data_head),
        .o_full  (w_data_full),
        .o_empty (w_data_empty)
    );

    tag_fifo #(.DEPTH(TAG_DEPTH)) u_sts_tag (
        .clk     (net_clk),
        .rst     (net_areset),
        .i_push  (w_accept),
        .i_data  (w_push_tag),
        .i_pop   (w_sts_pop),
        .o_data  (w_sts_head),
        .o_full  (w_sts_full),
        .o_empty (w_sts_empty)
    );

    // Zero-latency steering: the FIFO head picks which requester sees valid/ready.
    always_comb begin
        bus.m_req_data_valid = '0;
        bus.s_mem_data_ready = 1'b0;
        bus.m_req_sts_valid  = '0;
        bus.s_mem_sts_ready  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_data_empty && (w_data_head == tag_t'(i))) begin
                bus.m_req_data_valid[i] = bus.s_mem_data_valid;
                bus.s_mem_data_ready    = bus.m_req_data_ready[i];
            end
            if (!w_sts_empty && (w_sts_head == tag_t'(i))) begin
                bus.m_req_sts_valid[i]  = bus.s_mem_sts_valid;
                bus.s_mem_sts_ready     = bus.m_req_sts_ready[i];
            end
        end
    end

    assign w_data_pop = bus.s_mem_data_valid && bus.s_mem_data_ready && bus.s_mem_data_last;
    assign w_sts_pop  = bus.s_mem_sts_valid && bus.s_mem_sts_ready;

    assign bus.m_req_data      = bus.s_mem_data;
    assign bus.m_req_keep      = bus.s_mem_keep;
    assign bus.m_req_data_last = {NUM_REQ{bus.s_mem_data_last}};
    assign bus.m_req_sts_data  = bus.s_mem_sts_data;

    always_ff @(posedge net_clk or posedge net_areset) begin
        if (net_areset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_sts_pop})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign outstanding = r_outstanding;

endmodule
`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_read_arbiter
// Purpose  : Self-checking bench for mem_read_arbiter (NUM_REQ=2, TAG_DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_read_arbiter;
    import mem_arb_pkg::*;

    localparam int NUM_REQ   = 2;
    localparam int TAG_DEPTH = 8;

    logic       net_clk = 1'b0;
    logic       net_areset;
    logic [3:0] outstanding;

    mem_read_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    mem_read_arbiter #(.NUM_REQ(NUM_REQ), .TAG_DEPTH(TAG_DEPTH)) dut (
        .net_clk     (net_clk),
        .net_areset  (net_areset),
        .bus         (bus),
        .outstanding (outstanding)
    );

    always #5 net_clk = ~net_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: queues of requester indices in issue order.
    int              m_ptr;
    int              dq[$];
    int              sq[$];
    bit              m_mv;
    logic [63:0]     m_addr;
    logic [31:0]     m_len;

    // Per-step observations handed back to sequences
    int              last_acc;
    bit              mem_hs;
    logic [31:0]     hs_len;
    bit              d_hs;
    bit              s_pop;
    logic [1:0]      dut_cready;
    logic [1:0]      dut_dvalid;
    logic [1:0]      dut_svalid;
    logic            dut_dready;
    logic            dut_sready;
    logic [511:0]    drv_data;

    typedef struct {
        logic       dv;
        logic       dl;
        logic [1:0] drdy;
        logic       sv;
        logic [1:0] srdy;
        logic [1:0] exp_dvalid;
        logic       exp_dready;
        logic [1:0] exp_svalid;
        logic       exp_sready;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx = (m_ptr + k) % NUM_REQ;
            if (((v >> idx) & 2'b01) != 2'b00) return idx;
        end
        return -1;
    endfunction

    function automatic void model_clear();
        m_ptr = 0;
        dq.delete();
        sq.delete();
        m_mv   = 1'b0;
        m_addr = '0;
        m_len  = '0;
    endfunction

    task automatic set_data();
        for (int k = 0; k < 16; k++) drv_data[k*32 +: 32] = $urandom;
        bus.s_mem_data     = drv_data;
        bus.s_mem_keep     = {$urandom, $urandom};
        bus.s_mem_sts_data = 8'($urandom);
    endtask

    // Called at posedge+1 with inputs applied; checks outputs, advances one clock.
    task automatic step();
        int          g;
        bit          can;
        logic [1:0]  e_cr, e_dv, e_sv, oh;
        logic        e_dr, e_sr;
        logic [63:0] na;
        logic [31:0] nl;
        #3;
        g    = model_grant(bus.s_cmd_valid);
        can  = (!m_mv || bus.m_cmd_ready) && (dq.size() < TAG_DEPTH) && (sq.size() < TAG_DEPTH);
        e_cr = (g >= 0 && can) ? 2'(1 << g) : 2'b00;
        e_dv = 2'b00; e_dr = 1'b0; e_sv = 2'b00; e_sr = 1'b0;
        if (dq.size() > 0) begin
            oh   = 2'(1 << dq[0]);
            e_dv = bus.s_mem_data_valid ? oh : 2'b00;
            e_dr = |(bus.m_req_data_ready & oh);
        end
        if (sq.size() > 0) begin
            oh   = 2'(1 << sq[0]);
            e_sv = bus.s_mem_sts_valid ? oh : 2'b00;
            e_sr = |(bus.m_req_sts_ready & oh);
        end
        dut_cready = bus.s_cmd_ready;
        dut_dvalid = bus.m_req_data_valid;
        dut_dready = bus.s_mem_data_ready;
        dut_svalid = bus.m_req_sts_valid;
        dut_sready = bus.s_mem_sts_ready;
        check("s_cmd_ready", bus.s_cmd_ready, e_cr);
        check("m_cmd_valid", bus.m_cmd_valid, m_mv);
        if (m_mv) begin
            check("m_cmd_address", bus.m_cmd_address, m_addr);
            check("m_cmd_length", bus.m_cmd_length, m_len);
        end
        check("m_req_data_valid", bus.m_req_data_valid, e_dv);
        check("s_mem_data_ready", bus.s_mem_data_ready, e_dr);
        check("m_req_sts_valid", bus.m_req_sts_valid, e_sv);
        check("s_mem_sts_ready", bus.s_mem_sts_ready, e_sr);
        check("outstanding", outstanding, sq.size());
        if (bus.s_mem_data_valid) begin
            check("m_req_data_bcast", (bus.m_req_data !== drv_data) ? 1 : 0, 0);
            check("m_req_data_last", bus.m_req_data_last, {2{bus.s_mem_data_last}});
        end
        if (bus.s_mem_sts_valid) check("m_req_sts_data", bus.m_req_sts_data, bus.s_mem_sts_data);

        last_acc = (g >= 0 && can) ? g : -1;
        mem_hs   = m_mv && bus.m_cmd_ready;
        hs_len   = m_len;
        d_hs     = bus.s_mem_data_valid && e_dr;
        s_pop    = bus.s_mem_sts_valid && e_sr;
        na = '0; nl = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (k == g) begin
                na = bus.s_cmd_address[k];
                nl = bus.s_cmd_length[k];
            end
        end
        @(posedge net_clk);
        if (d_hs && bus.s_mem_data_last) void'(dq.pop_front());
        if (s_pop) void'(sq.pop_front());
        if (last_acc >= 0) begin
            dq.push_back(last_acc);
            sq.push_back(last_acc);
            m_mv   = 1'b1;
            m_addr = na;
            m_len  = nl;
`ifndef MEM_ARB_STRICT_PRIO_EN
            m_ptr  = (last_acc + 1) % NUM_REQ;
`endif
        end else if (mem_hs) begin
            m_mv = 1'b0;
        end
        #1;
    endtask

    // Reset with every valid high to show nothing leaks through while held.
    task automatic do_reset();
        net_areset           = 1'b1;
        bus.s_cmd_valid      = 2'b11;
        bus.m_cmd_ready      = 1'b1;
        bus.s_mem_data_valid = 1'b1;
        bus.s_mem_data_last  = 1'b1;
        bus.s_mem_sts_valid  = 1'b1;
        bus.m_req_data_ready = 2'b11;
        bus.m_req_sts_ready  = 2'b11;
        set_data();
        repeat (2) @(posedge net_clk);
        #4;
        check("rst_s_cmd_ready", bus.s_cmd_ready, 2'b00);
        check("rst_m_cmd_valid", bus.m_cmd_valid, 1'b0);
        check("rst_outstanding", outstanding, 4'd0);
        check("rst_s_mem_data_ready", bus.s_mem_data_ready, 1'b0);
        check("rst_s_mem_sts_ready", bus.s_mem_sts_ready, 1'b0);
        check("rst_m_req_data_valid", bus.m_req_data_valid, 2'b00);
        check("rst_m_req_sts_valid", bus.m_req_sts_valid, 2'b00);
        bus.s_cmd_valid      = 2'b00;
        bus.s_mem_data_valid = 1'b0;
        bus.s_mem_data_last  = 1'b0;
        bus.s_mem_sts_valid  = 1'b0;
        bus.m_req_data_ready = 2'b00;
        bus.m_req_sts_ready  = 2'b00;
        @(posedge net_clk);
        #1;
        net_areset = 1'b0;
        model_clear();
    endtask

    logic [1:0]  exp_rr[4];
    int          beats_q[$];
    int          sts_pending;
    logic [39:0] seq_no[2];

    initial begin
        bus.s_cmd_address = '0;
        bus.s_cmd_length  = '0;
        model_clear();

`ifdef MEM_ARB_STRICT_PRIO_EN
        exp_rr = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        // Both requesters always valid: grant pattern, then fill to TAG_DEPTH.
        do_reset();
        bus.s_cmd_address[0] = 64'h100;
        bus.s_cmd_address[1] = 64'h2000;
        bus.s_cmd_length[0]  = 32'd64;
        bus.s_cmd_length[1]  = 32'd128;
        bus.m_cmd_ready      = 1'b1;
        bus.s_cmd_valid      = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("arb_grant%0d", i), dut_cready, exp_rr[i]);
        end
        check("outstanding_after4", outstanding, 4'd4);
        repeat (4) step();
        step();
        check("full_stall_ready", dut_cready, 2'b00);
        check("full_outstanding", outstanding, 4'd8);

        // Back-pressure: registered command held for 5 cycles.
        do_reset();
        bus.s_cmd_address[0] = 64'hABC0;
        bus.s_cmd_length[0]  = 32'h80;
        bus.m_cmd_ready      = 1'b0;
        bus.s_cmd_valid      = 2'b01;
        step();
        bus.s_cmd_address[0] = 64'hDEAD0;
        bus.s_cmd_address[1] = 64'h5000;
        bus.s_cmd_valid      = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_address", bus.m_cmd_address, 64'hABC0);
            check("hold_length", bus.m_cmd_length, 32'h80);
            check("hold_no_accept", dut_cready, 2'b00);
        end
        bus.m_cmd_ready = 1'b1;
        step();
        bus.s_cmd_valid = 2'b00;
        step();

        // Req1 two-beat read then req0 one-beat read; table walks data/status.
        do_reset();
        bus.m_cmd_ready      = 1'b1;
        bus.s_cmd_address[1] = 64'h1000;
        bus.s_cmd_length[1]  = 32'd128;
        bus.s_cmd_valid      = 2'b10;
        step();
        bus.s_cmd_address[0] = 64'h3000;
        bus.s_cmd_length[0]  = 32'd64;
        bus.s_cmd_valid      = 2'b01;
        step();
        bus.s_cmd_valid      = 2'b00;
        step();
        vecs[0] = '{1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 2'b10, 1'b1, 2'b00, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 2'b01, 1'b1, 2'b10, 2'b10, 1'b0, 2'b10, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 2'b11, 1'b1, 2'b00, 2'b10, 1'b1, 2'b01, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 2'b01, 1'b1, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 2'b11, 1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0};
        for (int i = 0; i < 6; i++) begin
            bus.s_mem_data_valid = vecs[i].dv;
            bus.s_mem_data_last  = vecs[i].dl;
            bus.m_req_data_ready = vecs[i].drdy;
            bus.s_mem_sts_valid  = vecs[i].sv;
            bus.m_req_sts_ready  = vecs[i].srdy;
            set_data();
            step();
            check($sformatf("vec%0d_data_valid", i), dut_dvalid, vecs[i].exp_dvalid);
            check($sformatf("vec%0d_data_ready", i), dut_dready, vecs[i].exp_dready);
            check($sformatf("vec%0d_sts_valid", i), dut_svalid, vecs[i].exp_svalid);
            check($sformatf("vec%0d_sts_ready", i), dut_sready, vecs[i].exp_sready);
        end
        bus.s_mem_data_valid = 1'b0;
        bus.s_mem_sts_valid  = 1'b0;
        step();
        check("table_outstanding_zero", outstanding, 4'd0);

        // Randomized traffic against the queue model, memory replies in order.
        do_reset();
        beats_q.delete();
        sts_pending = 0;
        seq_no[0] = '0;
        seq_no[1] = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int g = 0; g < NUM_REQ; g++) begin
                if (!bus.s_cmd_valid[g] && ($urandom % 2 == 0)) begin
                    bus.s_cmd_valid[g]   = 1'b1;
                    bus.s_cmd_address[g] = {24'(g + 1), seq_no[g]};
                    bus.s_cmd_length[g]  = 32'($urandom_range(1, 256));
                    seq_no[g]            = seq_no[g] + 40'h40;
                end
            end
            bus.m_cmd_ready      = ($urandom % 4) != 0;
            bus.m_req_data_ready = 2'($urandom);
            bus.m_req_sts_ready  = 2'($urandom);
            bus.s_mem_data_valid = (beats_q.size() > 0) && ($urandom % 3 != 0);
            bus.s_mem_data_last  = (beats_q.size() > 0) && (beats_q[0] == 1);
            bus.s_mem_sts_valid  = (sts_pending > 0) && ($urandom % 2 == 0);
            set_data();
            step();
            if (last_acc >= 0) bus.s_cmd_valid = bus.s_cmd_valid & ~2'(1 << last_acc);
            if (d_hs) begin
                beats_q[0] = beats_q[0] - 1;
                if (beats_q[0] == 0) void'(beats_q.pop_front());
            end
            if (mem_hs) begin
                beats_q.push_back(int'((hs_len + 32'd63) / 32'd64));
                sts_pending++;
            end
            if (s_pop) sts_pending--;
        end

        // Reset with tags in flight, then confirm a clean idle cycle.
        do_reset();
        bus.m_cmd_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
